cla_adder_pipe: RTL and testbench

Parametrised two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshaking. It generalises the team's 4-bit lookahead adder to any multiple-of-4 width. It adds a subtract mode, carry/borrow-in, signed overflow and zero flags, and registered, back-pressurable output. It sits between operand producers and result consumers in datapath blocks that need wide adds at clock speed.

---
 rtl/adder_pkg.sv | 17 +
 rtl/cla_group4.sv | 22 ++
 rtl/cla_adder_pipe.sv | 183 ++++++++++++++++++
 tb/tb_cla_adder_pipe.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
package adder_pkg;

  // Bits per lookahead group.
  localparam int GROUP = 4;

  // Number of lookahead groups needed for a given operand width.
  function automatic int num_groups(input int width);
    return width / GROUP;
  endfunction

  // Width must be a non-zero whole number of groups.
  function automatic bit width_is_legal(input int width);
    return (width >= GROUP) && ((width % GROUP) == 0);
  endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead cell: in-group carries plus group propagate/generate.
module cla_group4 (
  input  logic [3:0] p_i,
  input  logic [3:0] g_i,
  input  logic       cin_i,
  output logic [2:0] c_o,        // c_o[j] is the carry into bit j+1
  output logic       group_p_o,
  output logic       group_g_o
);

  // Flat two-level lookahead equations, no rippling inside the group.
  always_comb begin
    c_o[0]    = g_i[0] | (p_i[0] & cin_i);
    c_o[1]    = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & cin_i);
    c_o[2]    = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
              | (p_i[2] & p_i[1] & p_i[0] & cin_i);
    group_p_o = &p_i;
    group_g_o = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
              | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
  end

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow.
//
// Handshake: a beat moves across an interface on a rising edge where its
// valid and ready are both high. Each stage advances when it is empty or the
// stage after it advances (s2_adv = !s2_valid | out_ready,
// s1_adv = !s1_valid | s2_adv, in_ready = s1_adv). in_ready therefore depends
// combinationally on out_ready; there is no skid buffer, so a stalled pipe
// holds two beats. Output fields stay frozen while out_valid=1 and
// out_ready=0.
module cla_adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             sub,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NG = num_groups(WIDTH);

  if (!width_is_legal(WIDTH)) begin : g_bad_width
    $error("cla_adder_pipe: WIDTH=%0d must be a multiple of %0d and at least %0d",
           WIDTH, GROUP, GROUP);
  end

  // ---------------------------------------------------------------- handshake
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_adv, s2_adv;

  assign s2_adv    = !s2_valid_q || out_ready;
  assign s1_adv    = !s1_valid_q || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;

  // Valid bits follow their upstream valid whenever the stage advances.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (s1_adv) s1_valid_d = in_valid;
    if (s2_adv) s2_valid_d = s1_valid_q;
  end

  // Valid registers; reset empties the pipe immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // ------------------------------------------------------------------ stage 1
  // Subtraction is A + ~B + !bin, so both B and the carry-in get inverted.
  logic [WIDTH-1:0] a_d, b_d, p_d, g_d;
  logic             cin_d;
  logic [NG-1:0]    gp_d, gg_d;
  logic [3*NG-1:0]  s1_carries_unused;

  assign a_d   = num1;
  assign b_d   = num2 ^ {WIDTH{sub}};
  assign cin_d = carry_in ^ sub;
  assign p_d   = a_d ^ b_d;
  assign g_d   = a_d & b_d;

  for (genvar k = 0; k < NG; k++) begin : g_s1_group
    cla_group4 u_grp (
      .p_i       (p_d[k*GROUP +: GROUP]),
      .g_i       (g_d[k*GROUP +: GROUP]),
      .cin_i     (1'b0),
      .c_o       (s1_carries_unused[k*3 +: 3]),
      .group_p_o (gp_d[k]),
      .group_g_o (gg_d[k])
    );
  end

  logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_p_q;
  logic [NG-1:0]    s1_gp_q, s1_gg_q;
  logic             s1_cin_q;

  // Stage-1 data loads only when a valid beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_p_q   <= '0;
      s1_gp_q  <= '0;
      s1_gg_q  <= '0;
      s1_cin_q <= 1'b0;
    end else if (s1_adv && in_valid) begin
      s1_a_q   <= a_d;
      s1_b_q   <= b_d;
      s1_p_q   <= p_d;
      s1_gp_q  <= gp_d;
      s1_gg_q  <= gg_d;
      s1_cin_q <= cin_d;
    end
  end

  // ------------------------------------------------------------------ stage 2
  logic [NG:0]      grp_c;
  logic [WIDTH-1:0] s2_g;
  logic [3*NG-1:0]  in_c;
  logic [NG-1:0]    s2_gp_unused, s2_gg_unused;
  logic [WIDTH-1:0] bit_c;

  assign s2_g = s1_a_q & s1_b_q;

  // Cross-group lookahead chain: c[k+1] = G[k] | P[k] & c[k].
  always_comb begin
    logic c;
    grp_c = '0;
    c     = s1_cin_q;
    for (int k = 0; k < NG; k++) begin
      grp_c[k] = c;
      c        = s1_gg_q[k] | (s1_gp_q[k] & c);
    end
    grp_c[NG] = c;
  end

  for (genvar k = 0; k < NG; k++) begin : g_s2_group
    cla_group4 u_grp (
      .p_i       (s1_p_q[k*GROUP +: GROUP]),
      .g_i       (s2_g[k*GROUP +: GROUP]),
      .cin_i     (grp_c[k]),
      .c_o       (in_c[k*3 +: 3]),
      .group_p_o (s2_gp_unused[k]),
      .group_g_o (s2_gg_unused[k])
    );
  end

  // Assemble the per-bit carry vector from group carries and in-group carries.
  always_comb begin
    bit_c = '0;
    for (int k = 0; k < NG; k++) begin
      bit_c[k*GROUP]          = grp_c[k];
      bit_c[k*GROUP+1 +: 3]   = in_c[k*3 +: 3];
    end
  end

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             carry_d, carry_q, ovf_d, ovf_q, zero_d, zero_q;

  assign sum_d   = s1_p_q ^ bit_c;
  assign carry_d = grp_c[NG];
  assign ovf_d   = bit_c[WIDTH-1] ^ grp_c[NG];
  assign zero_d  = (sum_d == '0);

  // Result registers load only when stage 2 advances with a valid beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (s2_adv && s1_valid_q) begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: directed cases on a 16-bit instance, then a
// randomized stream on 4-, 16- and 32-bit instances against an arithmetic model.
module tb_cla_adder_pipe;

  // ------------------------------------------------------- clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Index 0 -> WIDTH 4, 1 -> WIDTH 16, 2 -> WIDTH 32.
  logic        iv[3], ordy[3], sb[3], ci[3];
  logic [31:0] na[3], nb[3];

  logic        ir4, ov4, co4, of4, z4;
  logic [3:0]  s4;
  logic        ir16, ov16, co16, of16, z16;
  logic [15:0] s16;
  logic        ir32, ov32, co32, of32, z32;
  logic [31:0] s32;

  cla_adder_pipe #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir4),
    .num1(na[0][3:0]), .num2(nb[0][3:0]), .sub(sb[0]), .carry_in(ci[0]),
    .out_valid(ov4), .out_ready(ordy[0]), .sum(s4), .carry_out(co4),
    .overflow(of4), .zero(z4)
  );

  cla_adder_pipe #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir16),
    .num1(na[1][15:0]), .num2(nb[1][15:0]), .sub(sb[1]), .carry_in(ci[1]),
    .out_valid(ov16), .out_ready(ordy[1]), .sum(s16), .carry_out(co16),
    .overflow(of16), .zero(z16)
  );

  cla_adder_pipe #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir32),
    .num1(na[2]), .num2(nb[2]), .sub(sb[2]), .carry_in(ci[2]),
    .out_valid(ov32), .out_ready(ordy[2]), .sum(s32), .carry_out(co32),
    .overflow(of32), .zero(z32)
  );

  // ---------------------------------------------------------- bookkeeping
  int vectors    = 0;
  int miscompares = 0;

  // Packed result word: {zero, overflow, carry_out, sum[31:0]}.
  logic [34:0] exp_q0[$], exp_q1[$], exp_q2[$];

  function automatic int width_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 16 : 32;
  endfunction

  function automatic logic out_valid_of(input int d);
    return (d == 0) ? ov4 : (d == 1) ? ov16 : ov32;
  endfunction

  function automatic logic in_ready_of(input int d);
    return (d == 0) ? ir4 : (d == 1) ? ir16 : ir32;
  endfunction

  function automatic logic [34:0] obs(input int d);
    case (d)
      0:       return {z4, of4, co4, 28'd0, s4};
      1:       return {z16, of16, co16, 16'd0, s16};
      default: return {z32, of32, co32, s32};
    endcase
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : (d == 1) ? exp_q1.size() : exp_q2.size();
  endfunction

  function automatic logic [34:0] q_pop(input int d);
    case (d)
      0:       return exp_q0.pop_front();
      1:       return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  function automatic void q_push(input int d, input logic [34:0] v);
    case (d)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endfunction

  // Reference: plain integer arithmetic on A +/- B +/- cin.
  function automatic logic [34:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic s,
                                        input logic c);
    longint modv, half, ua, ub, cl, full, sa, sbv, r;
    logic [31:0] sm;
    logic co, ovf;
    modv = longint'(1) << w;
    half = modv / 2;
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    ua   = ua % modv;
    ub   = ub % modv;
    cl   = c ? 1 : 0;
    full = s ? (ua - ub - cl) : (ua + ub + cl);
    sm   = 32'(((full % modv) + modv) % modv);
    co   = s ? (full >= 0) : (full >= modv);
    sa   = (ua >= half) ? ua - modv : ua;
    sbv  = (ub >= half) ? ub - modv : ub;
    r    = s ? (sa - sbv - cl) : (sa + sbv + cl);
    ovf  = (r >= half) || (r < -half);
    return {(sm == 32'd0), ovf, co, sm};
  endfunction

  task automatic chk(input string tag, input logic [34:0] o, input logic [34:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Scoreboard step: called after inputs are driven at a falling edge.
  task automatic step(output logic [2:0] acc);
    logic [34:0] e;
    #1;
    acc = '0;
    for (int d = 0; d < 3; d++) begin
      if (out_valid_of(d) && ordy[d]) begin
        if (q_size(d) == 0) begin
          vectors++;
          assert (q_size(d) != 0) else begin
            miscompares++;
            $error("FAIL extra_beat_w%0d: observed %0h expected none", width_of(d), obs(d));
          end
        end else begin
          e = q_pop(d);
          chk($sformatf("stream_w%0d", width_of(d)), obs(d), e);
        end
      end
      if (iv[d] && in_ready_of(d)) begin
        acc[d] = 1'b1;
        q_push(d, model(width_of(d), na[d], nb[d], sb[d], ci[d]));
      end
    end
  endtask

  // One isolated beat on the 16-bit instance with an exact latency check.
  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic c, input logic [15:0] esum,
                          input logic eco, input logic eov, input logic ez);
    @(negedge clk);
    iv[1] = 1'b1; na[1] = {16'd0, a}; nb[1] = {16'd0, b}; sb[1] = s; ci[1] = c;
    ordy[1] = 1'b1;
    #1 chk({tag, "_in_ready"}, {34'd0, ir16}, 35'd1);
    @(negedge clk);
    iv[1] = 1'b0;
    #1 chk({tag, "_valid_n1"}, {34'd0, ov16}, 35'd0);
    @(negedge clk);
    #1;
    chk({tag, "_valid_n2"}, {34'd0, ov16}, 35'd1);
    chk({tag, "_sum"},      {19'd0, s16}, {19'd0, esum});
    chk({tag, "_carry"},    {34'd0, co16}, {34'd0, eco});
    chk({tag, "_ovf"},      {34'd0, of16}, {34'd0, eov});
    chk({tag, "_zero"},     {34'd0, z16}, {34'd0, ez});
  endtask

  // ------------------------------------------------------------- sequence
  initial begin
    logic [2:0]  acc;
    logic [34:0] held;
    logic [15:0] bp_a[4];
    logic [15:0] bp_b[4];
    int idx;

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; sb[d] = 1'b0; ci[d] = 1'b0;
      na[d] = '0; nb[d] = '0;
    end

    // Reset values.
    #2;
    chk("rst_out_valid", {34'd0, ov16}, 35'd0);
    chk("rst_in_ready",  {34'd0, ir16}, 35'd1);
    chk("rst_fields",    obs(1), 35'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) ordy[d] = 1'b1;

    // Directed arithmetic corners.
    directed("wrap",       16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    directed("pos_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    directed("neg_ovf",    16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    directed("borrow",     16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    directed("borrow_bin", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0);

    // Back-pressure: four beats with the consumer stalled.
    bp_a[0] = 16'h1111; bp_b[0] = 16'h0101;
    bp_a[1] = 16'hF000; bp_b[1] = 16'h1000;
    bp_a[2] = 16'h0003; bp_b[2] = 16'h0009;
    bp_a[3] = 16'h8001; bp_b[3] = 16'h8001;
    idx = 0;
    @(negedge clk);
    ordy[1] = 1'b0;
    sb[1] = 1'b0; ci[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[1] = 1'b1; na[1] = {16'd0, bp_a[idx]}; nb[1] = {16'd0, bp_b[idx]};
      #1 chk($sformatf("bp_in_ready_%0d", i), {34'd0, ir16}, (i < 2) ? 35'd1 : 35'd0);
      if (ir16) begin
        q_push(1, model(16, na[1], nb[1], sb[1], ci[1]));
        idx++;
      end
      @(negedge clk);
    end
    #1;
    held = obs(1);
    chk("bp_stall_valid", {34'd0, ov16}, 35'd1);
    @(negedge clk);
    #1;
    chk("bp_stall_stable", obs(1), held);
    chk("bp_stall_in_ready", {34'd0, ir16}, 35'd0);
    @(negedge clk);
    ordy[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      iv[1] = (idx < 4);
      if (idx < 4) begin
        na[1] = {16'd0, bp_a[idx]}; nb[1] = {16'd0, bp_b[idx]};
      end
      step(acc);
      chk($sformatf("bp_stream_valid_%0d", c), {34'd0, ov16}, 35'd1);
      if (acc[1]) idx++;
      @(negedge clk);
    end
    iv[1] = 1'b0;
    step(acc);
    @(negedge clk);
    chk("bp_drained", 35'(q_size(1)), 35'd0);

    // Reset with two beats queued behind a stalled consumer.
    ordy[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iv[1] = 1'b1; na[1] = $urandom; nb[1] = $urandom;
      step(acc);
      @(negedge clk);
    end
    iv[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {34'd0, ov16}, 35'd0);
    chk("midrst_fields",    obs(1), 35'd0);
    chk("midrst_in_ready",  {34'd0, ir16}, 35'd1);
    exp_q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ordy[1] = 1'b1;
    @(negedge clk);
    #1 chk("postrst_idle", {34'd0, ov16}, 35'd0);
    directed("postrst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);

    // Randomized streams on all three widths.
    @(negedge clk);
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int d = 0; d < 3; d++) begin
        iv[d]   = ($urandom_range(0, 3) != 0);
        ordy[d] = ($urandom_range(0, 3) != 0);
        na[d]   = $urandom;
        nb[d]   = $urandom;
        if ($urandom_range(0, 7) == 0) na[d] = nb[d];
        sb[d]   = 1'($urandom_range(0, 1));
        ci[d]   = 1'($urandom_range(0, 1));
      end
      step(acc);
      @(negedge clk);
    end
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b1;
    end
    for (int cyc = 0; cyc < 8; cyc++) begin
      step(acc);
      @(negedge clk);
    end
    for (int d = 0; d < 3; d++)
      chk($sformatf("count_w%0d", width_of(d)), 35'(q_size(d)), 35'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
